fastbconv_batch_ctrl: RTL

- Sequences a polynomial-wide fast base conversion over a small pool of LANES shared fastBConvSingle lanes instead of one lane per coefficient.
- Splits the N_SLOTS coefficients into batches. For each batch it launches all lanes together, waits for every active lane to finish, then pulses a write strobe so the surrounding datapath captures lane outputs into output_poly.
- Sits between the key-switch/rescale sequencer (start/done handshake) and the lane pool. The coefficient in/out muxes are external and are steered by batch_idx.

---
 rtl/fastbconv_batch_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fastbconv_batch_ctrl.sv
// Batch sequencer for a polynomial-wide fast base conversion: runs N_SLOTS coefficients
// through a pool of LANES shared fastBConvSingle lanes, one batch at a time.
module fastbconv_batch_ctrl #(
  parameter int N_SLOTS = 16,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 64,
  localparam int NUM_BATCHES = (N_SLOTS + LANES - 1) / LANES,
  localparam int BIDX_W      = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  output logic              busy,
  output logic              lane_start,
  output logic [BIDX_W-1:0] batch_idx,
  output logic [LANES-1:0]  lane_mask,
  input  logic [LANES-1:0]  lane_done,
  output logic              wr_en,
  output logic              done,
  output logic              err_timeout
);

  localparam int                TMR_W      = $clog2(TIMEOUT + 1);
  localparam logic [BIDX_W-1:0] LAST_BATCH = BIDX_W'(NUM_BATCHES - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t             state_r;
  logic [BIDX_W-1:0]  batch_idx_r;
  logic [LANES-1:0]   done_sticky_r;
  logic [TMR_W-1:0]   timer_r;
  logic               lane_start_r;
  logic               wr_en_r;
  logic               done_r;
  logic               err_timeout_r;
  logic               ready_r;
  logic               busy_r;
  logic [LANES-1:0]   lane_mask_s;
  logic               all_done_s;

  // Valid-lane mask of the current batch; only the last batch can be partial.
  always_comb begin
    lane_mask_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask_s[i] = ((int'(batch_idx_r) * LANES + i) < N_SLOTS);
    end
  end

  // A level or pulse on lane_done this cycle counts together with earlier pulses.
  assign all_done_s = (((done_sticky_r | lane_done) & lane_mask_s) == lane_mask_s);

  // Sequencer: every strobe is computed alongside the state transition that implies it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      batch_idx_r   <= '0;
      done_sticky_r <= '0;
      timer_r       <= '0;
      lane_start_r  <= 1'b0;
      wr_en_r       <= 1'b0;
      done_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      ready_r       <= 1'b1;
      busy_r        <= 1'b0;
    end else begin
      lane_start_r <= 1'b0;
      wr_en_r      <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_valid) begin
            batch_idx_r   <= '0;
            err_timeout_r <= 1'b0;
            lane_start_r  <= 1'b1;
            ready_r       <= 1'b0;
            busy_r        <= 1'b1;
            state_r       <= ST_LAUNCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          done_sticky_r <= '0;
          timer_r       <= TMR_LOAD;
          state_r       <= ST_WAIT;
        end
        ST_WAIT: begin
          done_sticky_r <= done_sticky_r | (lane_done & lane_mask_s);
          if (all_done_s) begin
            wr_en_r <= 1'b1;
            state_r <= ST_WRITE;
          end else if (timer_r == TMR_W'(1)) begin
            err_timeout_r <= 1'b1;
            done_r        <= 1'b1;
            state_r       <= ST_FIN;
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        ST_WRITE: begin
          if (batch_idx_r == LAST_BATCH) begin
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end else begin
            batch_idx_r  <= batch_idx_r + BIDX_W'(1);
            lane_start_r <= 1'b1;
            state_r      <= ST_LAUNCH;
          end
        end
        ST_FIN: begin
          batch_idx_r <= '0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          batch_idx_r <= '0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready = ready_r;
  assign busy        = busy_r;
  assign lane_start  = lane_start_r;
  assign batch_idx   = batch_idx_r;
  assign lane_mask   = lane_mask_s;
  assign wr_en       = wr_en_r;
  assign done        = done_r;
  assign err_timeout = err_timeout_r;

endmodule
